alu_issue: RTL
==============

// Module: alu_issue
// PURPOSE
// Execute-stage front end for the alu block. Accepts a fetched RV32 R-type or OP-IMM instruction
// with its register operands over a valid/ready handshake. Decodes it to the 5-bit ALU opcode,
// drives operands to the alu through an EX pipeline register, and captures Y/zero into a WB register.
// Sits between register-file read and writeback; throughput one instruction per cycle.
// PARAMETERS
// XLEN      32   datapath width; alu_a/alu_b/alu_y/wb_data width
// PORTS
// clk         in   1     rising-edge clock
// rst_n       in   1     asynchronous active-low reset
// flush       in   1     synchronous kill of EX and WB contents
// in_valid    in   1     instruction/operands valid
// in_ready    out  1     stage can accept this cycle
// in_inst     in   32    raw instruction word
// in_rs1      in   XLEN  rs1 register value
// in_rs2      in   XLEN  rs2 register value (ignored for OP-IMM)
// alu_a       out  XLEN  ALU operand A (registered)
// alu_b       out  XLEN  ALU operand B (registered)
// alu_op      out  5     ALU opcode (registered)
// alu_y       in   XLEN  ALU result (combinational from alu)
// alu_zero    in   1     ALU zero flag
// wb_valid    out  1     writeback entry valid
// wb_ready    in   1     writeback consumer accepts
// wb_rd       out  5     destination register
// wb_data     out  XLEN  captured ALU result
// wb_zero     out  1     captured zero flag
// illegal     out  1     one-cycle pulse: accepted instruction was unsupported
// BEHAVIOUR
// - Reset: ex_valid=0, wb_valid=0, alu_a=alu_b=0, alu_op=5'b00000, wb_rd=0, wb_data=0, wb_zero=0, illegal=0.
// - Opcode map {f7[5],f7[0],f3}: ADD 00000, SUB 10000, MUL 01000, SLL 00001, OR 00110, AND 00111.
// - R-type (inst[6:0]=0110011): funct7 in {0000000,0100000,0000001} and the mapped code in the set above;
//   alu_a=rs1, alu_b=rs2.
// - OP-IMM (0010011): ADDI f3=000 -> 00000; ORI 110 -> 00110; ANDI 111 -> 00111;
//   SLLI 001 requires inst[31:25]=0 -> 00001.
// - OP-IMM operand B: sign-extended inst[31:20] (ADDI/ORI/ANDI), or zero-extended inst[24:20] (SLLI).
// - All other encodings are illegal.
// - SLL (R-type): alu_b = {0, rs2[4:0]}; shift amount masked to 5 bits.
// - Pipeline control:
//   - wb_adv = !wb_valid | wb_ready.
//   - ex_adv = ex_valid & wb_adv.
//   - in_ready = !flush & (!ex_valid | ex_adv).
// - Accept (in_valid & in_ready), legal instruction: load alu_a/alu_b/alu_op/rd; ex_valid=1 next cycle.
// - Accept, illegal instruction: not loaded; ex_valid clears if ex_adv; illegal=1 on the next cycle only.
// - ex_adv: wb_data<=alu_y, wb_zero<=alu_zero, wb_rd<=ex rd, wb_valid<=1. Else if wb_ready, wb_valid<=0.
// - Latency: accepted at edge N -> alu_* valid after N, wb_valid after edge N+1. Back-to-back at full rate.
// - Stall: wb_valid & !wb_ready holds WB and EX unchanged, with alu_* stable; in_ready=0 if ex_valid.
// - flush=1: ex_valid and wb_valid clear at the next edge; no accept that cycle; illegal not raised.
//   flush beats a simultaneous wb_ready.
// - rd=x0 passes through unchanged; consumer discards.
// - Async reset mid-stream: all state cleared immediately, in-flight instructions lost.
// CONFIGURATION
// ALU_ISSUE_MUL_EN
// - Defined: R-type funct7=0000001 funct3=000 decodes to MUL (01000).
// - Undefined: that encoding is illegal (pulse, dropped); alu_op never equals 01000.
// TESTING
// - ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, wb_ready=1 -> alu_op=00000; wb_data=12, wb_rd=3 after 2 cycles.
// - SUB x5,x6,x6 (0x406302B3), rs1=rs2=9 -> alu_op=10000, wb_data=0, wb_zero=1.
// - ADDI x1,x0,-1 (0xFFF00093), rs1=0 -> alu_b=0xFFFFFFFF; wb_data=0xFFFFFFFF.
// - SLLI x2,x1,4 (0x00409113), rs1=3 -> alu_op=00001, alu_b=4, wb_data=48.
// - SLLI with inst[31:25]=0100000 -> illegal pulse 1 cycle, no wb_valid.
// - Stream 4 ADDs, wb_ready low 3 cycles mid-stream -> in_ready drops, no loss or duplication, order kept.
// - MUL (0x022081B3), rs1=6, rs2=7: with macro wb_data=42; without, illegal pulse, nothing written.
// - flush with EX and WB both valid, wb_ready=0 -> both valids 0 next cycle, no wb handshake.

Source files
------------

// File: rtl/alu_issue.sv
//==============================================================================
// alu_issue : RV32 R-type / OP-IMM decode feeding an external alu through an
//             EX operand register, with the alu result captured in a WB register.
// Option    : define ALU_ISSUE_MUL_EN to decode R-type MUL (funct7=0000001, f3=000).
// Revision  : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_flush,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [31:0]     i_in_inst,
   input  logic [XLEN-1:0] i_in_rs1,
   input  logic [XLEN-1:0] i_in_rs2,
   output logic [XLEN-1:0] o_alu_a,
   output logic [XLEN-1:0] o_alu_b,
   output logic [4:0]      o_alu_op,
   input  logic [XLEN-1:0] i_alu_y,
   input  logic            i_alu_zero,
   output logic            o_wb_valid,
   input  logic            i_wb_ready,
   output logic [4:0]      o_wb_rd,
   output logic [XLEN-1:0] o_wb_data,
   output logic            o_wb_zero,
   output logic            o_illegal
);

   localparam logic [6:0] c_OPC_OP    = 7'b0110011;
   localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;

   logic            r_ex_valid;
   logic [XLEN-1:0] r_alu_a;
   logic [XLEN-1:0] r_alu_b;
   logic [4:0]      r_alu_op;
   logic [4:0]      r_ex_rd;
   logic            r_wb_valid;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_data;
   logic            r_wb_zero;
   logic            r_illegal;

   logic [6:0]      w_f7;
   logic [2:0]      w_f3;
   logic [4:0]      w_code;
   logic            w_legal;
   logic [4:0]      w_op;
   logic [XLEN-1:0] w_b;
   logic            w_wb_adv;
   logic            w_ex_adv;
   logic            w_in_ready;
   logic            w_accept;
   logic            w_unused_rs1_field;

   assign w_f7   = i_in_inst[31:25];
   assign w_f3   = i_in_inst[14:12];
   assign w_code = {w_f7[5], w_f7[0], w_f3};
   assign w_unused_rs1_field = ^i_in_inst[19:15];

   // Operand B defaults to rs2; immediates and 5-bit shift amounts override it.
   always_comb begin
      w_legal = 1'b0;
      w_op    = 5'b00000;
      w_b     = i_in_rs2;
      case (i_in_inst[6:0])
         c_OPC_OP: begin
            if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000 || w_f7 == 7'b0000001) begin
               w_op = w_code;
               case (w_code)
                  5'b00000, 5'b10000, 5'b00110, 5'b00111: w_legal = 1'b1;
                  5'b00001: begin
                     w_legal = 1'b1;
                     w_b     = {{(XLEN-5){1'b0}}, i_in_rs2[4:0]};
                  end
`ifdef ALU_ISSUE_MUL_EN
                  5'b01000: w_legal = 1'b1;
`endif
                  default: w_legal = 1'b0;
               endcase
            end
         end
         c_OPC_OPIMM: begin
            w_op = {2'b00, w_f3};
            w_b  = {{(XLEN-12){i_in_inst[31]}}, i_in_inst[31:20]};
            case (w_f3)
               3'b000, 3'b110, 3'b111: w_legal = 1'b1;
               3'b001: begin
                  w_legal = (w_f7 == 7'b0000000);
                  w_b     = {{(XLEN-5){1'b0}}, i_in_inst[24:20]};
               end
               default: w_legal = 1'b0;
            endcase
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign w_wb_adv   = !r_wb_valid || i_wb_ready;
   assign w_ex_adv   = r_ex_valid && w_wb_adv;
   assign w_in_ready = !i_flush && (!r_ex_valid || w_ex_adv);
   assign w_accept   = i_in_valid && w_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_op   <= 5'b00000;
         r_ex_rd    <= 5'd0;
      end else if (i_flush) begin
         r_ex_valid <= 1'b0;
      end else if (w_accept && w_legal) begin
         r_ex_valid <= 1'b1;
         r_alu_a    <= i_in_rs1;
         r_alu_b    <= w_b;
         r_alu_op   <= w_op;
         r_ex_rd    <= i_in_inst[11:7];
      end else if (w_ex_adv) begin
         r_ex_valid <= 1'b0;
      end
   end

   // Flush takes priority over both the EX->WB move and a WB drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= 5'd0;
         r_wb_data  <= '0;
         r_wb_zero  <= 1'b0;
      end else if (i_flush) begin
         r_wb_valid <= 1'b0;
      end else if (w_ex_adv) begin
         r_wb_valid <= 1'b1;
         r_wb_rd    <= r_ex_rd;
         r_wb_data  <= i_alu_y;
         r_wb_zero  <= i_alu_zero;
      end else if (i_wb_ready) begin
         r_wb_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_accept && !w_legal;
      end
   end

   assign o_in_ready = w_in_ready;
   assign o_alu_a    = r_alu_a;
   assign o_alu_b    = r_alu_b;
   assign o_alu_op   = r_alu_op;
   assign o_wb_valid = r_wb_valid;
   assign o_wb_rd    = r_wb_rd;
   assign o_wb_data  = r_wb_data;
   assign o_wb_zero  = r_wb_zero;
   assign o_illegal  = r_illegal;

endmodule

`default_nettype wire
